// File: rtl/fht_pkg.sv
// Shared definitions for the FHT bank unloader: controller states, bank count
// and the address bit-reversal used to walk rows in transform output order.
package fht_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } fht_state_e;

    localparam int BANK_COUNT = 4;
    localparam int REV_MAX    = 16;
    localparam int REV_IDX_W  = $clog2(REV_MAX);

    // Reverse the low 'width' bits of val; bits at or above width come back as zero.
    function automatic logic [REV_MAX-1:0] bit_rev(input logic [REV_MAX-1:0] val, input int width);
        logic [REV_MAX-1:0] res;
        res = {REV_MAX{1'b0}};
        for (int i = 0; i < REV_MAX; i++) begin
            if (i < width) begin
                res[i] = val[REV_IDX_W'(width - 1 - i)];
            end else begin
                res[i] = 1'b0;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/fht_reader.sv
// Unloads the four FHT result banks as one sample stream in bit-reversed row
// order, double-buffering rows so the stream runs without bubbles at full rate.
module fht_reader
    import fht_pkg::*;
#(
    parameter int D_BIT  = 22,
    parameter int A_BIT  = 9,
    parameter int RD_LAT = 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iFHT_RDY,
    input  logic [D_BIT-1:0] iDATA_0,
    input  logic [D_BIT-1:0] iDATA_1,
    input  logic [D_BIT-1:0] iDATA_2,
    input  logic [D_BIT-1:0] iDATA_3,
    output logic [A_BIT-1:0] oADDR_RD,
    output logic [D_BIT-1:0] oDATA,
    output logic             oVALID,
    input  logic             iREADY,
    output logic             oLAST,
    output logic             oBUSY,
    output logic             oDONE
);

    localparam int BANK_SIZE = 2 ** A_BIT;
    localparam logic [A_BIT-1:0] LAST_ROW = A_BIT'(BANK_SIZE - 1);

    fht_state_e       state_r, state_s;
    logic             rdy_d_r, armed_r;
    logic [A_BIT-1:0] addr_r, row_r;
    logic [1:0]       word_r;
    logic [RD_LAT:0]  rd_sr_r;
    logic [D_BIT-1:0] buf0_r [BANK_COUNT];
    logic [D_BIT-1:0] buf1_r [BANK_COUNT];
    logic [D_BIT-1:0] rd_row_s [BANK_COUNT];
    logic             v0_r, v1_r;
    logic [D_BIT-1:0] data_r;
    logic             last_r, busy_r, done_r;

    logic             start_s, cap_s, xfer_s, row_end_s, last_row_s;
    logic             advance_s, finish_s, swap_s, direct_s, fill_s, enter_s, issue_s;
    logic [A_BIT-1:0] new_row_s, issue_row_s;

    // Datapath strobes: start edge, read capture, transfers and row hand-over
    always_comb begin
        rd_row_s[0] = iDATA_0;
        rd_row_s[1] = iDATA_1;
        rd_row_s[2] = iDATA_2;
        rd_row_s[3] = iDATA_3;
        start_s    = (state_r == ST_IDLE) && iFHT_RDY && !rdy_d_r && armed_r;
        cap_s      = rd_sr_r[RD_LAT];
        xfer_s     = v0_r && iREADY;
        row_end_s  = (state_r == ST_SEND) && xfer_s && (word_r == 2'd3);
        last_row_s = (row_r == LAST_ROW);
        advance_s  = row_end_s && !last_row_s;
        finish_s   = row_end_s && last_row_s;
        swap_s     = advance_s && v1_r;
        // A capture landing on the word-3 transfer feeds the output buffer directly.
        direct_s   = advance_s && !v1_r && cap_s;
        fill_s     = (state_r == ST_FETCH) && cap_s;
        enter_s    = fill_s || swap_s || direct_s;
        if (fill_s) begin
            new_row_s = row_r;
        end else begin
            new_row_s = row_r + A_BIT'(1);
        end
        if (start_s) begin
            issue_s     = 1'b1;
            issue_row_s = {A_BIT{1'b0}};
        end else if (enter_s && (new_row_s != LAST_ROW)) begin
            issue_s     = 1'b1;
            issue_row_s = new_row_s + A_BIT'(1);
        end else begin
            issue_s     = 1'b0;
            issue_row_s = new_row_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) state_s = ST_FETCH;
                else         state_s = ST_IDLE;
            end
            ST_FETCH: begin
                if (cap_s) state_s = ST_SEND;
                else       state_s = ST_FETCH;
            end
            ST_SEND: begin
                if (finish_s)                          state_s = ST_DONE;
                else if (advance_s && !v1_r && !cap_s) state_s = ST_FETCH;
                else                                   state_s = ST_SEND;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register and start-edge detection; armed only after a low level is seen
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            state_r <= ST_IDLE;
            rdy_d_r <= 1'b0;
            armed_r <= 1'b0;
        end else begin
            state_r <= state_s;
            rdy_d_r <= iFHT_RDY;
            if (!iFHT_RDY) armed_r <= 1'b1;
        end
    end

    // Read issue, outstanding-read tracking and row/word position
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            addr_r  <= {A_BIT{1'b0}};
            rd_sr_r <= {(RD_LAT + 1){1'b0}};
            row_r   <= {A_BIT{1'b0}};
            word_r  <= 2'd0;
        end else begin
            rd_sr_r <= {rd_sr_r[RD_LAT-1:0], issue_s};
            if (issue_s) addr_r <= A_BIT'(bit_rev(REV_MAX'(issue_row_s), A_BIT));
            if (start_s)        row_r <= {A_BIT{1'b0}};
            else if (advance_s) row_r <= row_r + A_BIT'(1);
            if (start_s || fill_s || advance_s) word_r <= 2'd0;
            else if (xfer_s)                    word_r <= word_r + 2'd1;
        end
    end

    // Row buffers and registered output stream
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            for (int i = 0; i < BANK_COUNT; i++) begin
                buf0_r[i] <= {D_BIT{1'b0}};
                buf1_r[i] <= {D_BIT{1'b0}};
            end
            v0_r   <= 1'b0;
            v1_r   <= 1'b0;
            data_r <= {D_BIT{1'b0}};
            last_r <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (fill_s || direct_s) buf0_r <= rd_row_s;
            else if (swap_s)        buf0_r <= buf1_r;
            if (cap_s && (state_r == ST_SEND) && !direct_s) begin
                buf1_r <= rd_row_s;
                v1_r   <= 1'b1;
            end else if (swap_s) begin
                v1_r   <= 1'b0;
            end
            if (enter_s)        v0_r <= 1'b1;
            else if (row_end_s) v0_r <= 1'b0;
            if (fill_s || direct_s)            data_r <= iDATA_0;
            else if (swap_s)                   data_r <= buf1_r[0];
            else if (xfer_s && word_r != 2'd3) data_r <= buf0_r[word_r + 2'd1];
            if (enter_s)                          last_r <= 1'b0;
            else if (xfer_s && word_r == 2'd2)    last_r <= last_row_s;
            else if (row_end_s)                   last_r <= 1'b0;
            if (start_s)       busy_r <= 1'b1;
            else if (finish_s) busy_r <= 1'b0;
            done_r <= finish_s;
        end
    end

    assign oADDR_RD = addr_r;
    assign oDATA    = data_r;
    assign oVALID   = v0_r;
    assign oLAST    = last_r;
    assign oBUSY    = busy_r;
    assign oDONE    = done_r;

endmodule

// File: tb/tb_fht_reader.sv
// Directed bench for fht_reader with an 8-row, 4-bank RAM model holding 100*bank + addr.
module tb_fht_reader;

    localparam int D_BIT  = 22;
    localparam int A_BIT  = 3;
    localparam int RD_LAT = 2;

    logic             iCLK, iRESET, iFHT_RDY, iREADY;
    logic [D_BIT-1:0] iDATA_0, iDATA_1, iDATA_2, iDATA_3;
    logic [A_BIT-1:0] oADDR_RD;
    logic [D_BIT-1:0] oDATA;
    logic             oVALID, oLAST, oBUSY, oDONE;
    logic [A_BIT-1:0] ap1, ap2;

    int n_tests = 0;
    int n_fail  = 0;
    int addr_tab [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int addr_seq [8];
    int n_addr, n_out, n_done, done_k, fv_k;

    fht_reader #(.D_BIT(D_BIT), .A_BIT(A_BIT), .RD_LAT(RD_LAT)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iFHT_RDY(iFHT_RDY),
        .iDATA_0(iDATA_0), .iDATA_1(iDATA_1), .iDATA_2(iDATA_2), .iDATA_3(iDATA_3),
        .oADDR_RD(oADDR_RD), .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY),
        .oLAST(oLAST), .oBUSY(oBUSY), .oDONE(oDONE)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    // Bank RAM model: data valid RD_LAT cycles after the address
    always @(posedge iCLK) begin
        ap1 <= oADDR_RD;
        ap2 <= ap1;
    end
    assign iDATA_0 = 22'd0   + 22'(ap2);
    assign iDATA_1 = 22'd100 + 22'(ap2);
    assign iDATA_2 = 22'd200 + 22'(ap2);
    assign iDATA_3 = 22'd300 + 22'(ap2);

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_addr();
        chk("addr_count", 64'(n_addr), 64'd8);
        for (int i = 0; i < 8; i++) begin
            chk("addr_seq", 64'(addr_seq[i]), 64'(addr_tab[i]));
        end
    endtask

    // mode 0: ready=1, 1: ready toggles, 2: 20-cycle stall, 3: extra start pulse, 4: reset at sample 15
    task automatic unload(input int mode);
        int               pulse_k;
        logic             prev_stall, prev_last;
        logic [D_BIT-1:0] prev_data;
        logic [A_BIT-1:0] prev_addr;
        n_out = 0; n_done = 0; done_k = -1; fv_k = -1; n_addr = 0; pulse_k = -1;
        prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0; prev_addr = '0;
        for (int i = 0; i < 8; i++) addr_seq[i] = -1;
        iREADY = 1'b0;
        iFHT_RDY = 1'b0;
        tick();
        iFHT_RDY = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if (k == 1) begin
                iFHT_RDY = 1'b0;
                chk("busy_after_edge", 64'(oBUSY), 64'd1);
            end
            if (mode == 3 && n_out == 10 && pulse_k < 0) begin
                iFHT_RDY = 1'b1;
                pulse_k = k;
            end else if (pulse_k >= 0 && k == pulse_k + 1) begin
                iFHT_RDY = 1'b0;
            end
            if (oBUSY && (n_addr == 0 || oADDR_RD !== prev_addr)) begin
                if (n_addr < 8) addr_seq[n_addr] = int'(oADDR_RD);
                n_addr++;
                prev_addr = oADDR_RD;
            end
            if (oVALID && fv_k < 0) fv_k = k;
            if (prev_stall) begin
                chk("stall_valid", 64'(oVALID), 64'd1);
                chk("stall_data", 64'(oDATA), 64'(prev_data));
                chk("stall_last", 64'(oLAST), 64'(prev_last));
            end
            if (mode == 4 && oVALID && n_out == 15) begin
                iRESET = 1'b0;
                #1;
                chk("rst_valid", 64'(oVALID), 64'd0);
                chk("rst_last", 64'(oLAST), 64'd0);
                chk("rst_busy", 64'(oBUSY), 64'd0);
                chk("rst_done", 64'(oDONE), 64'd0);
                chk("rst_data", 64'(oDATA), 64'd0);
                chk("rst_addr", 64'(oADDR_RD), 64'd0);
                iFHT_RDY = 1'b1;
                repeat (3) tick();
                iRESET = 1'b1;
                for (int j = 0; j < 8; j++) begin
                    tick();
                    chk("no_restart_busy", 64'(oBUSY), 64'd0);
                    chk("no_restart_valid", 64'(oVALID), 64'd0);
                    if (oDONE) n_done++;
                end
                break;
            end
            case (mode)
                1:       iREADY = (k % 2 == 0);
                2:       iREADY = (fv_k >= 0) && (k >= fv_k + 20);
                default: iREADY = 1'b1;
            endcase
            if (mode == 2 && oVALID && !iREADY) chk("hold_zero", 64'(oDATA), 64'd0);
            if (oVALID && iREADY) begin
                if (n_out < 32) begin
                    chk("sample_data", 64'(oDATA), 64'(100 * (n_out % 4) + addr_tab[n_out / 4]));
                    chk("sample_last", 64'(oLAST), 64'(n_out == 31));
                end else begin
                    chk("extra_sample", 64'(n_out), 64'd31);
                end
                n_out++;
            end
            prev_stall = oVALID && !iREADY;
            prev_data  = oDATA;
            prev_last  = oLAST;
            if (oDONE) begin
                n_done++;
                if (done_k < 0) done_k = k;
            end
            if (done_k >= 0 && k >= done_k + 4) begin
                chk("idle_after_done", 64'(oBUSY), 64'd0);
                break;
            end
            tick();
        end
    endtask

    initial begin
        iRESET = 1'b0;
        iFHT_RDY = 1'b0;
        iREADY = 1'b0;
        repeat (3) tick();
        chk("reset_valid", 64'(oVALID), 64'd0);
        chk("reset_last", 64'(oLAST), 64'd0);
        chk("reset_busy", 64'(oBUSY), 64'd0);
        chk("reset_done", 64'(oDONE), 64'd0);
        chk("reset_data", 64'(oDATA), 64'd0);
        chk("reset_addr", 64'(oADDR_RD), 64'd0);
        iRESET = 1'b1;
        tick();

        unload(0);
        chk("m0_count", 64'(n_out), 64'd32);
        chk("m0_done_pulses", 64'(n_done), 64'd1);
        chk("m0_first_valid", 64'(fv_k), 64'd4);
        chk("m0_done_cycle", 64'(done_k), 64'd36);
        chk_addr();

        unload(1);
        chk("toggle_count", 64'(n_out), 64'd32);
        chk("toggle_done_pulses", 64'(n_done), 64'd1);
        chk_addr();

        unload(2);
        chk("stall_count", 64'(n_out), 64'd32);
        chk("stall_done_pulses", 64'(n_done), 64'd1);
        chk("stall_first_valid", 64'(fv_k), 64'd4);
        chk_addr();

        unload(3);
        chk("pulse_count", 64'(n_out), 64'd32);
        chk("pulse_done_pulses", 64'(n_done), 64'd1);

        unload(4);
        chk("abort_samples", 64'(n_out), 64'd15);
        chk("abort_no_done", 64'(n_done), 64'd0);

        unload(0);
        chk("restart_count", 64'(n_out), 64'd32);
        chk("restart_done_pulses", 64'(n_done), 64'd1);
        chk("restart_first_valid", 64'(fv_k), 64'd4);
        chk("restart_done_cycle", 64'(done_k), 64'd36);
        chk_addr();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
